shift_add_multiplier_8bit: RTL and testbench

//  Sequential 8x8 unsigned multiplier using the shift-and-add method.
//  It drives operands into one full_adder_8bit instance and consumes that adder's {cout,s} result every cycle.
//  It computes one partial-product step per clock and returns a 16-bit product.
//  It has valid/ready handshakes on the input side and on the output side.

---
 rtl/mult_pkg.sv | 14 +
 rtl/full_adder_8bit.sv | 19 +
 rtl/shift_add_multiplier_8bit.sv | 124 ++++++++++++
 tb/tb_shift_add_multiplier_8bit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and default operand/counter widths.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 8;
  localparam int unsigned MULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_8bit.sv
// 8-bit ripple-style adder with carry in/out; {cout,s} = a + b + cin.
module full_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] sum;

  // Nine-bit sum keeps the carry out of the top bit.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    s    = sum[7:0];
    cout = sum[8];
  end

endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential unsigned shift-and-add multiplier, one partial-product step per
// clock, valid/ready on both sides.
// Optional macro EARLY_TERM_EN: a zero operand skips the CALC steps and the
// accept goes straight to DONE with a zero product.
module shift_add_multiplier_8bit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   add_s;
  logic               add_cout;

  full_adder_8bit full_adder_8bit_u (
    .a    (mcand_q),
    .b    (p_hi_q),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // Next-state logic: operand load, shift/add step, completion and drain.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    p_hi_d      = p_hi_q;
    p_lo_d      = p_lo_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = a;
          p_hi_d     = '0;
          p_lo_d     = b;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
`ifdef EARLY_TERM_EN
          if ((a == '0) || (b == '0)) begin
            p_lo_d      = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      CALC: begin
        // Shift the 2*WIDTH+1 bit value {carry, high, low} right by one;
        // the carry lands in the top bit of the high half.
        if (p_lo_q[0]) begin
          p_hi_d = {add_cout, add_s[WIDTH-1:1]};
          p_lo_d = {add_s[0], p_lo_q[WIDTH-1:1]};
        end else begin
          p_hi_d = {1'b0, p_hi_q[WIDTH-1:1]};
          p_lo_d = {p_hi_q[0], p_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      p_hi_q      <= '0;
      p_lo_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      p_hi_q      <= p_hi_d;
      p_lo_q      <= p_lo_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Self-checking bench for shift_add_multiplier_8bit; expected products come
// from plain a*b and expected latency from the operand values.
module tb_shift_add_multiplier_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier_8bit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accept edge until out_valid is seen high.
  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef EARLY_TERM_EN
    if (x == 8'd0 || y == 8'd0) return 0;
`endif
    return 8;
  endfunction

  // Present one operand pair, return product and edges until out_valid.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] prod, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    prod = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%0d, want 1 0 0",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat;
    out_ready = 1'b1;
    do_op(8'd3, 8'd5, p, lat);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if (p !== 16'd15) begin errors++; $display("FAIL basic_product: got %0d want 15", p); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max();
    logic [15:0] p; int lat;
    out_ready = 1'b1;
    do_op(8'd255, 8'd255, p, lat);
    checks++;
    if (p !== 16'd65025 || lat !== 8) begin
      errors++;
      $display("FAIL max_product: got %0d lat %0d want 65025 lat 8", p, lat);
    end
    tick();
  endtask

  task automatic test_zero();
    logic [15:0] p; int lat;
    out_ready = 1'b1;
    do_op(8'd0, 8'd200, p, lat);
    checks++;
    if (p !== 16'd0 || lat !== exp_lat(8'd0, 8'd200)) begin
      errors++;
      $display("FAIL zero_a: got %0d lat %0d want 0 lat %0d", p, lat, exp_lat(8'd0, 8'd200));
    end
    tick();
    do_op(8'd200, 8'd0, p, lat);
    checks++;
    if (p !== 16'd0 || lat !== exp_lat(8'd200, 8'd0)) begin
      errors++;
      $display("FAIL zero_b: got %0d lat %0d want 0 lat %0d", p, lat, exp_lat(8'd200, 8'd0));
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] p; int lat;
    out_ready = 1'b0;
    do_op(8'd17, 8'd13, p, lat);
    checks++;
    if (p !== 16'd221 || lat !== 8) begin
      errors++;
      $display("FAIL bp_product: got %0d lat %0d want 221 lat 8", p, lat);
    end
    // New operands offered while stalled must be ignored.
    a = 8'd99; b = 8'd99; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || product !== 16'd221 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b product=%0d in_ready=%b want 1 221 0",
                 i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; int lat;
    out_ready = 1'b1;
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b product=%0d want 0 1 0",
               out_valid, in_ready, product);
    end
    // No stale result may appear after the aborted operation.
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) begin
        checks++; errors++;
        $display("FAIL mid_reset_stale: out_valid=1 at cycle %0d want 0", i);
      end
    end
    do_op(8'd7, 8'd9, p, lat);
    checks++;
    if (p !== 16'd63 || lat !== 8) begin
      errors++;
      $display("FAIL after_reset: got %0d lat %0d want 63 lat 8", p, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq[$];
    int idx, got, cyc;
    bit acc, drn;
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    a = 8'd0; b = 8'd0; in_valid = 1'b1;
    while (got < 256 && cyc < 5000) begin
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected product %0d", product);
        end else begin
          if (product !== expq[0]) begin
            errors++;
            $display("FAIL b2b_product[%0d]: got %0d want %0d", got, product, expq[0]);
          end
          void'(expq.pop_front());
        end
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        expq.push_back(16'(a) * 16'(b));
        idx++;
        if (idx < 256) begin
          a = 8'(idx / 16); b = 8'(idx % 16);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 256 || expq.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, %0d pending, want 256 and 0", got, expq.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] p; int lat; int stall;
    logic [7:0] x, y;
    for (int n = 0; n < 30; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if (n % 10 == 3) x = 8'd0;
      stall = int'($urandom_range(0, 3));
      out_ready = 1'b0;
      do_op(x, y, p, lat);
      checks++;
      if (p !== 16'(x) * 16'(y) || lat !== exp_lat(x, y)) begin
        errors++;
        $display("FAIL rand[%0d] %0d*%0d: got %0d lat %0d want %0d lat %0d",
                 n, x, y, p, lat, 16'(x) * 16'(y), exp_lat(x, y));
      end
      for (int s = 0; s < stall; s++) tick();
      checks++;
      if (out_valid !== 1'b1 || product !== 16'(x) * 16'(y)) begin
        errors++;
        $display("FAIL rand_hold[%0d]: out_valid=%b product=%0d want 1 %0d",
                 n, out_valid, product, 16'(x) * 16'(y));
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
